// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI shift engine.
//   state_e           - frame sequencer states
//   CPHA_*            - meaning of the cphase configuration bit
//   clamp_len()       - maps a requested frame length onto 1..max_len
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic CPHA_LEAD_SAMPLE  = 1'b0;
  localparam logic CPHA_TRAIL_SAMPLE = 1'b1;

  // A length of zero, or anything beyond the datapath width, means "full width".
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: bundles the shift engine's control, config, strobe and
// serial signals.
//   slave  modport - the shift engine (consumes config/strobes, drives results)
//   master modport - the register block / baud generator side
interface spi_shift_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
);
  logic              ss_i;
  logic              start_i;
  logic [DATA_W-1:0] tx_data_i;
  logic [LEN_W-1:0]  len_i;
  logic              lsbfe_i;
  logic              cphase_i;
  logic              lead_edge_i;
  logic              trail_edge_i;
  logic              miso_i;
  logic              mosi_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              busy_o;
  logic              abort_o;

  modport slave (
    input  ss_i, start_i, tx_data_i, len_i, lsbfe_i, cphase_i,
           lead_edge_i, trail_edge_i, miso_i,
    output mosi_o, rx_data_o, rx_valid_o, busy_o, abort_o
  );

  modport master (
    output ss_i, start_i, tx_data_i, len_i, lsbfe_i, cphase_i,
           lead_edge_i, trail_edge_i, miso_i,
    input  mosi_o, rx_data_o, rx_valid_o, busy_o, abort_o
  );
endinterface

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: counts sampled bits of a frame.
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - clear count to zero (has priority over inc_i)
//   inc_i     - count one sampled bit
//   len_i     - frame length
//   count_o   - bits sampled so far
//   term_o    - this increment brings the count to len_i
module spi_bit_counter #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] count_o,
  output logic             term_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  // Flag the terminal sample in the same cycle so the sequencer leaves SHIFT
  // without waiting a cycle for the registered count.
  assign term_o  = inc_i && (cnt_inc == len_i);

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex SPI shift engine with runtime frame length,
// MSB/LSB-first order and CPHA-selected sample/drive edges.
//   PCLK    - system clock
//   PRESET  - asynchronous active-high reset
//   bus     - slave modport: ss_i/start_i/config/edge strobes/miso_i in,
//             mosi_o/rx_data_o/rx_valid_o/busy_o/abort_o out
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
  input logic                PCLK,
  input logic                PRESET,
  spi_shift_engine_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              lsb_q, lsb_d;
  logic              cpha_q, cpha_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              abort_q, abort_d;

  logic [LEN_W-1:0]  len_in_cl, first_idx, drive_idx, cnt;
  logic              first_bit, drive_bit;
  logic              lead, trail, in_shift, sample, drive, cnt_clr, cnt_term;
  logic [DATA_W-1:0] rx_next;

  assign len_in_cl = LEN_W'(clamp_len(32'(bus.len_i), DATA_W));

  // The k-th bit on the wire (k = samples taken so far) is tx[k] LSB-first or
  // tx[len-1-k] MSB-first; a mask-and-reduce picks it without a narrow index.
  assign first_idx = bus.lsbfe_i ? '0 : len_in_cl - LEN_W'(1);
  assign first_bit = |(bus.tx_data_i & (DATA_W'(1) << first_idx));
  assign drive_idx = lsb_q ? cnt : len_q - LEN_W'(1) - cnt;
  assign drive_bit = |(tx_q & (DATA_W'(1) << drive_idx));

  // A trail strobe coinciding with a lead strobe is dropped.
  assign lead     = bus.lead_edge_i;
  assign trail    = bus.trail_edge_i & ~bus.lead_edge_i;
  assign in_shift = (state_q == ST_SHIFT) && !bus.ss_i;
  assign sample   = in_shift && ((cpha_q == CPHA_LEAD_SAMPLE) ? lead : trail);
  assign drive    = in_shift && ((cpha_q == CPHA_TRAIL_SAMPLE) ? lead : trail);
  assign cnt_clr  = (state_q == ST_LOAD);

  spi_bit_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr_i   (cnt_clr),
    .inc_i   (sample),
    .len_i   (len_q),
    .count_o (cnt),
    .term_o  (cnt_term)
  );

  assign rx_next = lsb_q ? (rx_sh_q | (DATA_W'(bus.miso_i) << cnt))
                         : {rx_sh_q[DATA_W-2:0], bus.miso_i};

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    cpha_d     = cpha_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (bus.start_i && !bus.ss_i) begin
          tx_d    = bus.tx_data_i;
          len_d   = len_in_cl;
          lsb_d   = bus.lsbfe_i;
          cpha_d  = bus.cphase_i;
          busy_d  = 1'b1;
          mosi_d  = (bus.cphase_i == CPHA_LEAD_SAMPLE) ? first_bit : 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD, ST_SHIFT: begin
        if (bus.ss_i) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (state_q == ST_LOAD) begin
          rx_sh_d = '0;
          state_d = ST_SHIFT;
        end else if (sample) begin
          rx_sh_d = rx_next;
          if (cnt_term) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else if (drive) begin
          mosi_d = drive_bit;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      cpha_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      cpha_q     <= cpha_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.mosi_o     = mosi_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.abort_o    = abort_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed self-checking bench for spi_shift_engine
// (DATA_W=16). Inputs change 1ns after a rising edge; outputs are checked there.
module tb_spi_shift_engine;

  logic PCLK;
  logic PRESET;
  int unsigned n_vec;
  int unsigned n_err;

  spi_shift_engine_if #(.DATA_W(16)) bus ();

  spi_shift_engine #(.DATA_W(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete frame. seq[k] is the k-th MISO bit on the wire; with loop=1
  // MISO mirrors MOSI instead. poke=1 raises start_i mid-frame.
  task automatic frame(input string nm, input logic [15:0] tx, input logic [4:0] len,
                       input logic lsb, input logic cpha, input logic [15:0] seq,
                       input logic loop, input logic poke, input logic [15:0] exp_rx);
    int unsigned n;
    logic [15:0] eb;
    n  = (len == 0 || len > 16) ? 16 : int'(len);
    eb = '0;
    for (int unsigned k = 0; k < n; k++) eb[k] = lsb ? tx[k] : tx[n-1-k];
    bus.tx_data_i = tx; bus.len_i = len; bus.lsbfe_i = lsb; bus.cphase_i = cpha;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    // Config changes after acceptance must not matter.
    bus.tx_data_i = ~tx; bus.len_i = 5'd3; bus.lsbfe_i = ~lsb; bus.cphase_i = ~cpha;
    chk({nm, " load busy"}, bus.busy_o, 1);
    chk({nm, " load mosi"}, bus.mosi_o, cpha ? 1'b0 : eb[0]);
    tick();
    for (int unsigned k = 0; k < n; k++) begin
      if (poke && k == 1) bus.start_i = 1'b1;
      if (!cpha) begin
        chk($sformatf("%s mosi%0d", nm, k), bus.mosi_o, eb[k]);
        bus.miso_i = loop ? bus.mosi_o : seq[k];
        bus.lead_edge_i = 1'b1;
        tick();
        bus.lead_edge_i = 1'b0; bus.start_i = 1'b0;
        if (k < n - 1) begin
          chk($sformatf("%s novalid%0d", nm, k), bus.rx_valid_o, 0);
          bus.trail_edge_i = 1'b1;
          tick();
          bus.trail_edge_i = 1'b0;
        end
      end else begin
        bus.lead_edge_i = 1'b1;
        tick();
        bus.lead_edge_i = 1'b0; bus.start_i = 1'b0;
        chk($sformatf("%s mosi%0d", nm, k), bus.mosi_o, eb[k]);
        bus.miso_i = loop ? bus.mosi_o : seq[k];
        bus.trail_edge_i = 1'b1;
        tick();
        bus.trail_edge_i = 1'b0;
        if (k < n - 1) chk($sformatf("%s novalid%0d", nm, k), bus.rx_valid_o, 0);
      end
    end
    chk({nm, " valid"}, bus.rx_valid_o, 1);
    chk({nm, " rx"}, bus.rx_data_o, exp_rx);
    chk({nm, " done busy"}, bus.busy_o, 1);
    bus.trail_edge_i = 1'b1;  // trailing strobe after the last sample: ignored
    tick();
    bus.trail_edge_i = 1'b0;
    chk({nm, " valid pulse"}, bus.rx_valid_o, 0);
    chk({nm, " idle busy"}, bus.busy_o, 0);
    chk({nm, " idle mosi"}, bus.mosi_o, 0);
    chk({nm, " rx held"}, bus.rx_data_o, exp_rx);
    bus.miso_i = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    PRESET = 1'b1;
    bus.ss_i = 1'b0; bus.start_i = 1'b0; bus.tx_data_i = '0; bus.len_i = '0;
    bus.lsbfe_i = 1'b0; bus.cphase_i = 1'b0; bus.lead_edge_i = 1'b0;
    bus.trail_edge_i = 1'b0; bus.miso_i = 1'b0;
    tick(); tick();
    chk("rst mosi", bus.mosi_o, 0);
    chk("rst rx", bus.rx_data_o, 0);
    chk("rst valid", bus.rx_valid_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst abort", bus.abort_o, 0);
    PRESET = 1'b0;
    tick();

    frame("msb_cpha0", 16'h00A5, 5'd8, 0, 0, 16'h003C, 0, 0, 16'h003C);
    frame("lsb_cpha1", 16'h00A5, 5'd8, 1, 1, 16'h0003, 0, 0, 16'h0003);
    frame("len0_loop", 16'hBEEF, 5'd0, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    frame("len1",      16'h0001, 5'd1, 0, 0, 16'h0000, 0, 0, 16'h0000);
    frame("poke_lsb",  16'h0ABC, 5'd12, 1, 1, 16'h0000, 1, 1, 16'h0ABC);
    frame("len20",     16'h1234, 5'd20, 0, 1, 16'h0000, 1, 0, 16'h1234);

    // Abort after three samples.
    bus.tx_data_i = 16'h00FF; bus.len_i = 5'd8; bus.lsbfe_i = 1'b0; bus.cphase_i = 1'b0;
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      bus.miso_i = 1'b1; bus.lead_edge_i = 1'b1; tick(); bus.lead_edge_i = 1'b0;
      bus.trail_edge_i = 1'b1; tick(); bus.trail_edge_i = 1'b0;
    end
    bus.miso_i = 1'b0;
    bus.ss_i = 1'b1;
    tick();
    chk("abort pulse", bus.abort_o, 1);
    chk("abort busy", bus.busy_o, 0);
    chk("abort novalid", bus.rx_valid_o, 0);
    chk("abort rx kept", bus.rx_data_o, 16'h1234);
    chk("abort mosi", bus.mosi_o, 0);
    bus.start_i = 1'b1;  // ss_i high: start ignored
    tick();
    bus.start_i = 1'b0;
    chk("abort one cycle", bus.abort_o, 0);
    chk("start ss high", bus.busy_o, 0);
    bus.ss_i = 1'b0;
    tick();
    frame("after_abort", 16'h005A, 5'd7, 0, 0, 16'h0000, 1, 0, 16'h005A);

    // Reset mid-frame.
    bus.tx_data_i = 16'h8000; bus.len_i = 5'd16; bus.lsbfe_i = 1'b0; bus.cphase_i = 1'b0;
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0; tick();
    bus.miso_i = 1'b1; bus.lead_edge_i = 1'b1; tick(); bus.lead_edge_i = 1'b0;
    chk("prerst mosi", bus.mosi_o, 1);
    PRESET = 1'b1;
    #1;
    chk("midrst mosi", bus.mosi_o, 0);
    chk("midrst busy", bus.busy_o, 0);
    chk("midrst rx", bus.rx_data_o, 0);
    chk("midrst valid", bus.rx_valid_o, 0);
    chk("midrst abort", bus.abort_o, 0);
    tick();
    PRESET = 1'b0; bus.miso_i = 1'b0;
    tick();
    chk("postrst busy", bus.busy_o, 0);

    // cphase=0, lead+trail together: sample happens, MOSI does not advance.
    bus.tx_data_i = 16'h0002; bus.len_i = 5'd2; bus.lsbfe_i = 1'b0; bus.cphase_i = 1'b0;
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    chk("both0 load mosi", bus.mosi_o, 1);
    tick();
    bus.miso_i = 1'b1; bus.lead_edge_i = 1'b1; tick();
    chk("both0 mosi hold", bus.mosi_o, 1);
    bus.trail_edge_i = 1'b1; tick();
    bus.lead_edge_i = 1'b0; bus.trail_edge_i = 1'b0; bus.miso_i = 1'b0;
    chk("both0 valid", bus.rx_valid_o, 1);
    chk("both0 rx", bus.rx_data_o, 16'h0003);
    chk("both0 mosi", bus.mosi_o, 1);
    bus.ss_i = 1'b1;  // ss_i in DONE: no abort
    tick();
    chk("done ss noabort", bus.abort_o, 0);
    chk("done ss busy", bus.busy_o, 0);
    bus.ss_i = 1'b0;

    // cphase=1, lead+trail together: drive happens, no sample.
    bus.tx_data_i = 16'h0001; bus.len_i = 5'd1; bus.lsbfe_i = 1'b0; bus.cphase_i = 1'b1;
    bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
    chk("both1 load mosi", bus.mosi_o, 0);
    tick();
    bus.miso_i = 1'b1; bus.lead_edge_i = 1'b1; bus.trail_edge_i = 1'b1; tick();
    bus.lead_edge_i = 1'b0;
    chk("both1 mosi", bus.mosi_o, 1);
    chk("both1 nosample", bus.rx_valid_o, 0);
    bus.miso_i = 1'b0; tick();
    bus.trail_edge_i = 1'b0;
    chk("both1 valid", bus.rx_valid_o, 1);
    chk("both1 rx", bus.rx_data_o, 16'h0000);
    tick();
    chk("both1 idle", bus.busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
